// File: rtl/gs_mem_arbiter.sv
// gs_mem_arbiter: shares the single byte-wide General Sound memory port
// between the GS CPU and the ROM/data loader byte stream. Loader writes are
// queued in a small FIFO and the two requesters are granted round-robin.
// GS accesses beyond the configured GS memory size complete without a memory
// cycle: reads return 8'hFF and writes are dropped.
//
// Optional feature macro: GS_MEM_ARBITER_RDCACHE_EN
//   When defined, a one-entry GS read latch lets a repeated in-range read of
//   the last address complete without a memory cycle.
//
// Ports:
//   clk_sys, reset         clock; synchronous active-high reset
//   gs_size                0 = 512KB, 1 = 1MB, 2/3 = 2MB
//   gs_addr, gs_din        GS address and write data
//   gs_rd, gs_wr           GS request levels, held until gs_wait is low
//   gs_dout                GS read data (registered)
//   gs_wait                GS access pending (combinational)
//   ld_wr, ld_addr, ld_data loader write strobe and payload
//   ld_full                loader FIFO full (registered)
//   mem_addr, mem_din      memory address and write data (registered)
//   mem_rd, mem_wr         memory request, held until mem_ready (registered)
//   mem_dout, mem_ready    memory read data and completion pulse
module gs_mem_arbiter #(
  parameter int unsigned ADDR_W        = 21,
  parameter int unsigned LD_FIFO_DEPTH = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [1:0]        gs_size,
  input  logic [ADDR_W-1:0] gs_addr,
  input  logic [7:0]        gs_din,
  input  logic              gs_rd,
  input  logic              gs_wr,
  output logic [7:0]        gs_dout,
  output logic              gs_wait,
  input  logic              ld_wr,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_full,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [7:0]        mem_dout,
  input  logic              mem_ready
);

  localparam int unsigned PTR_W = (LD_FIFO_DEPTH > 1) ? $clog2(LD_FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LD_FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, GS_MEM, LD_MEM, GS_OOR} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } ld_entry_t;

  state_t            state, state_d;
  logic              last_grant, last_grant_d;  // 1 = loader granted last
  logic              op_wr, op_wr_d;            // current GS op is a write
  logic [7:0]        cpl_data, cpl_data_d;      // read data for memory-less completion
  logic [ADDR_W-1:0] mem_addr_d;
  logic [7:0]        mem_din_d;
  logic              mem_rd_d, mem_wr_d;
  logic [7:0]        gs_dout_d;

  logic              done, done_set;
  logic [ADDR_W-1:0] done_addr;
  logic              done_rd, done_wr;

  logic              gsp, oor, rc_hit;
  logic [7:0]        rc_q;
  logic              grant_gs, grant_ld;

  ld_entry_t         fifo_mem [LD_FIFO_DEPTH];
  ld_entry_t         head;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_d;
  logic              push, pop, fifo_full;

  // GS request is pending until its completion is latched in done
  assign gsp     = (gs_rd | gs_wr) & ~done;
  assign gs_wait = gsp;

  // Address beyond the configured GS memory size
  always_comb begin
    case (gs_size)
      2'd0:    oor = |gs_addr[20:19];
      2'd1:    oor = gs_addr[20];
      default: oor = 1'b0;
    endcase
  end

  // Round-robin: on contention, grant whoever was not granted last
  assign grant_ld = (state == IDLE) & (count != '0) & (~gsp | ~last_grant);
  assign grant_gs = (state == IDLE) & gsp & ~grant_ld;

  // Loader FIFO
  assign head      = fifo_mem[rd_ptr];
  assign fifo_full = (count == FULL_CNT);
  assign pop       = grant_ld;
  assign push      = ld_wr & (~fifo_full | pop);
  assign count_d   = count + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ld_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count_d;
      ld_full <= (count_d == FULL_CNT);
    end
  end

  // FIFO storage needs no reset; pointers define validity
  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wr_ptr] <= {ld_addr, ld_data};
  end

`ifdef GS_MEM_ARBITER_RDCACHE_EN
  logic              rc_valid;
  logic [ADDR_W-1:0] rc_addr;
  logic [7:0]        rc_data;

  // One-entry read latch: filled by GS memory reads, dropped by writes to it
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rc_valid <= 1'b0;
      rc_addr  <= '0;
      rc_data  <= 8'h00;
    end else if ((state == GS_MEM) & mem_ready & ~op_wr) begin
      rc_valid <= 1'b1;
      rc_addr  <= mem_addr;
      rc_data  <= mem_dout;
    end else if ((grant_gs & gs_wr & (rc_addr == gs_addr)) |
                 (grant_ld & (rc_addr == head.addr))) begin
      rc_valid <= 1'b0;
    end
  end

  assign rc_hit = rc_valid & (rc_addr == gs_addr);
  assign rc_q   = rc_data;
`else
  assign rc_hit = 1'b0;
  assign rc_q   = 8'hFF;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    op_wr_d      = op_wr;
    cpl_data_d   = cpl_data;
    mem_addr_d   = mem_addr;
    mem_din_d    = mem_din;
    mem_rd_d     = mem_rd;
    mem_wr_d     = mem_wr;
    gs_dout_d    = gs_dout;
    done_set     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_ld) begin
          last_grant_d = 1'b1;
          mem_addr_d   = head.addr;
          mem_din_d    = head.data;
          mem_wr_d     = 1'b1;
          state_d      = LD_MEM;
        end else if (grant_gs) begin
          last_grant_d = 1'b0;
          op_wr_d      = gs_wr;
          if (oor) begin
            cpl_data_d = 8'hFF;
            state_d    = GS_OOR;
          end else if (rc_hit & ~gs_wr) begin
            cpl_data_d = rc_q;
            state_d    = GS_OOR;
          end else begin
            mem_addr_d = gs_addr;
            mem_din_d  = gs_din;
            mem_rd_d   = ~gs_wr;
            mem_wr_d   = gs_wr;
            state_d    = GS_MEM;
          end
        end
      end
      GS_MEM: begin
        if (mem_ready) begin
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          done_set = 1'b1;
          if (~op_wr) gs_dout_d = mem_dout;
          state_d  = IDLE;
        end
      end
      LD_MEM: begin
        if (mem_ready) begin
          mem_wr_d = 1'b0;
          state_d  = IDLE;
        end
      end
      GS_OOR: begin
        done_set = 1'b1;
        if (~op_wr) gs_dout_d = cpl_data;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      op_wr      <= 1'b0;
      cpl_data   <= 8'hFF;
      mem_addr   <= '0;
      mem_din    <= 8'h00;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      gs_dout    <= 8'hFF;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      op_wr      <= op_wr_d;
      cpl_data   <= cpl_data_d;
      mem_addr   <= mem_addr_d;
      mem_din    <= mem_din_d;
      mem_rd     <= mem_rd_d;
      mem_wr     <= mem_wr_d;
      gs_dout    <= gs_dout_d;
    end
  end

  // Done latch: blocks re-issue of a completed GS access until its request changes
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      done      <= 1'b0;
      done_addr <= '0;
      done_rd   <= 1'b0;
      done_wr   <= 1'b0;
    end else if (done_set) begin
      done      <= 1'b1;
      done_addr <= gs_addr;
      done_rd   <= gs_rd;
      done_wr   <= gs_wr;
    end else if (done & ((~gs_rd & ~gs_wr) | (gs_addr != done_addr) |
                         (gs_rd != done_rd) | (gs_wr != done_wr))) begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gs_mem_arbiter.sv
// tb_gs_mem_arbiter: directed bench for gs_mem_arbiter with a small memory
// responder that can withhold mem_ready.
module tb_gs_mem_arbiter;
  localparam int unsigned ADDR_W = 21;

  logic              clk_sys, reset;
  logic [1:0]        gs_size;
  logic [ADDR_W-1:0] gs_addr;
  logic [7:0]        gs_din;
  logic              gs_rd, gs_wr;
  logic [7:0]        gs_dout;
  logic              gs_wait;
  logic              ld_wr;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_data;
  logic              ld_full;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              mem_rd, mem_wr;
  logic [7:0]        mem_dout;
  logic              mem_ready;

  logic              ready_en, kick;
  logic              ready_q = 1'b0;
  logic [7:0]        dout_q  = 8'h00;
  logic [7:0]        model [logic [ADDR_W-1:0]];
  logic              acc_wr_q   [$];
  logic [ADDR_W-1:0] acc_addr_q [$];
  logic [7:0]        acc_data_q [$];
  int                rd_cnt = 0, wr_cnt = 0, req_cycles = 0;
  int                checks, failures;

  gs_mem_arbiter #(.ADDR_W(ADDR_W), .LD_FIFO_DEPTH(4)) dut (
    .clk_sys(clk_sys), .reset(reset), .gs_size(gs_size),
    .gs_addr(gs_addr), .gs_din(gs_din), .gs_rd(gs_rd), .gs_wr(gs_wr),
    .gs_dout(gs_dout), .gs_wait(gs_wait),
    .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data), .ld_full(ld_full),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .mem_ready(mem_ready)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  assign mem_ready = ready_q | kick;
  assign mem_dout  = kick ? 8'h77 : dout_q;

  // Unwritten locations read as low address byte XOR 8'h3C
  function automatic logic [7:0] model_rd(input logic [ADDR_W-1:0] a);
    if (model.exists(a)) return model[a];
    return a[7:0] ^ 8'h3C;
  endfunction

  // Memory responder: ready one cycle after a request is first seen
  always @(posedge clk_sys) begin
    if (mem_rd | mem_wr) req_cycles = req_cycles + 1;
    if (ready_en && (mem_rd || mem_wr) && !ready_q) begin
      ready_q <= 1'b1;
      acc_wr_q.push_back(mem_wr);
      acc_addr_q.push_back(mem_addr);
      if (mem_wr) begin
        model[mem_addr] = mem_din;
        acc_data_q.push_back(mem_din);
        wr_cnt = wr_cnt + 1;
      end else begin
        dout_q <= model_rd(mem_addr);
        acc_data_q.push_back(model_rd(mem_addr));
        rd_cnt = rd_cnt + 1;
      end
    end else begin
      ready_q <= 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Drive a GS access, count negedges until gs_wait low, then release it
  task automatic gs_access(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [7:0] d, output int n);
    gs_addr = a; gs_din = d; gs_rd = rd; gs_wr = wr;
    #1;
    n = 0;
    while (gs_wait && n < 50) begin @(negedge clk_sys); n++; end
    gs_rd = 1'b0; gs_wr = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic ld_push(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    ld_addr = a; ld_data = d; ld_wr = 1'b1;
    @(negedge clk_sys);
    ld_wr = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL reset_mem_rd got=%0b exp=0", mem_rd); end
    checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL reset_mem_wr got=%0b exp=0", mem_wr); end
    checks++; if (mem_addr !== 21'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_din !== 8'h00) begin failures++; $display("FAIL reset_mem_din got=%h exp=00", mem_din); end
    checks++; if (gs_dout !== 8'hFF) begin failures++; $display("FAIL reset_gs_dout got=%h exp=ff", gs_dout); end
    checks++; if (ld_full !== 1'b0) begin failures++; $display("FAIL reset_ld_full got=%0b exp=0", ld_full); end
    checks++; if (gs_wait !== 1'b0) begin failures++; $display("FAIL reset_gs_wait got=%0b exp=0", gs_wait); end
    reset = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_gs_rw;
    int n, wr0, rd0, base;
    gs_size = 2'd2;
    wr0 = wr_cnt; rd0 = rd_cnt; base = acc_addr_q.size();
    gs_addr = 21'h1FFFFF; gs_din = 8'h5A; gs_wr = 1'b1;
    #1;
    checks++; if (gs_wait !== 1'b1) begin failures++; $display("FAIL rw_first_wait got=%0b exp=1", gs_wait); end
    n = 0;
    while (gs_wait && n < 50) begin @(negedge clk_sys); n++; end
    gs_wr = 1'b0;
    @(negedge clk_sys);
    checks++; if (n != 3) begin failures++; $display("FAIL rw_wr_latency got=%0d exp=3", n); end
    checks++; if (wr_cnt != wr0 + 1) begin failures++; $display("FAIL rw_wr_count got=%0d exp=%0d", wr_cnt, wr0 + 1); end
    checks++; if (acc_addr_q[base] !== 21'h1FFFFF) begin failures++; $display("FAIL rw_wr_addr got=%h exp=1fffff", acc_addr_q[base]); end
    checks++; if (acc_data_q[base] !== 8'h5A) begin failures++; $display("FAIL rw_wr_data got=%h exp=5a", acc_data_q[base]); end
    gs_access(1'b1, 1'b0, 21'h1FFFFF, 8'h00, n);
    checks++; if (n != 3) begin failures++; $display("FAIL rw_rd_latency got=%0d exp=3", n); end
    checks++; if (rd_cnt != rd0 + 1) begin failures++; $display("FAIL rw_rd_count got=%0d exp=%0d", rd_cnt, rd0 + 1); end
    checks++; if (acc_addr_q[base+1] !== 21'h1FFFFF) begin failures++; $display("FAIL rw_rd_addr got=%h exp=1fffff", acc_addr_q[base+1]); end
    checks++; if (gs_dout !== 8'h5A) begin failures++; $display("FAIL rw_rd_data got=%h exp=5a", gs_dout); end
  endtask

  task automatic test_oor;
    int n, wr0, rd0;
    wr0 = wr_cnt; rd0 = rd_cnt;
    gs_size = 2'd0;
    gs_access(1'b1, 1'b0, 21'h080000, 8'h00, n);
    checks++; if (n != 2) begin failures++; $display("FAIL oor_rd_latency got=%0d exp=2", n); end
    checks++; if (gs_dout !== 8'hFF) begin failures++; $display("FAIL oor_rd_data got=%h exp=ff", gs_dout); end
    checks++; if (rd_cnt != rd0) begin failures++; $display("FAIL oor_rd_nomem got=%0d exp=%0d", rd_cnt, rd0); end
    gs_size = 2'd1;
    gs_access(1'b0, 1'b1, 21'h100000, 8'h33, n);
    checks++; if (n != 2) begin failures++; $display("FAIL oor_wr_latency got=%0d exp=2", n); end
    checks++; if (wr_cnt != wr0) begin failures++; $display("FAIL oor_wr_nomem got=%0d exp=%0d", wr_cnt, wr0); end
    // Highest in-range address for 1MB goes to memory
    gs_access(1'b1, 1'b0, 21'h0FFFFF, 8'h00, n);
    checks++; if (n != 3) begin failures++; $display("FAIL inrange_rd_latency got=%0d exp=3", n); end
    checks++; if (rd_cnt != rd0 + 1) begin failures++; $display("FAIL inrange_rd_count got=%0d exp=%0d", rd_cnt, rd0 + 1); end
    checks++; if (gs_dout !== 8'hC3) begin failures++; $display("FAIL inrange_rd_data got=%h exp=c3", gs_dout); end
  endtask

  task automatic test_fifo_full;
    int n, wr0, base;
    logic [ADDR_W-1:0] ea;
    logic [7:0] ed;
    gs_size = 2'd2;
    ready_en = 1'b0;
    wr0 = wr_cnt; base = acc_addr_q.size();
    gs_addr = 21'h000010; gs_rd = 1'b1;
    repeat (2) @(negedge clk_sys);
    for (int i = 0; i < 5; i++) begin
      ld_addr = ADDR_W'(32'h100 + i); ld_data = 8'(8'hA0 + i); ld_wr = 1'b1;
      @(negedge clk_sys);
      if (i == 2) begin
        checks++; if (ld_full !== 1'b0) begin failures++; $display("FAIL fifo_not_full_3 got=%0b exp=0", ld_full); end
      end
      if (i == 3) begin
        checks++; if (ld_full !== 1'b1) begin failures++; $display("FAIL fifo_full_4 got=%0b exp=1", ld_full); end
      end
    end
    ld_wr = 1'b0;
    checks++; if (ld_full !== 1'b1) begin failures++; $display("FAIL fifo_full_5 got=%0b exp=1", ld_full); end
    ready_en = 1'b1;
    n = 0;
    while (gs_wait && n < 50) begin @(negedge clk_sys); n++; end
    checks++; if (gs_wait !== 1'b0) begin failures++; $display("FAIL fifo_gs_timeout got=%0b exp=0", gs_wait); end
    checks++; if (gs_dout !== 8'h2C) begin failures++; $display("FAIL fifo_gs_data got=%h exp=2c", gs_dout); end
    gs_rd = 1'b0;
    n = 0;
    while (wr_cnt < wr0 + 4 && n < 100) begin @(negedge clk_sys); n++; end
    repeat (10) @(negedge clk_sys);
    checks++; if (wr_cnt != wr0 + 4) begin failures++; $display("FAIL fifo_wr_count got=%0d exp=%0d", wr_cnt, wr0 + 4); end
    for (int i = 0; i < 4; i++) begin
      ea = ADDR_W'(32'h100 + i);
      ed = 8'(8'hA0 + i);
      checks++;
      if (acc_wr_q[base+1+i] !== 1'b1 || acc_addr_q[base+1+i] !== ea || acc_data_q[base+1+i] !== ed) begin
        failures++;
        $display("FAIL fifo_order_%0d got=wr%0b %h %h exp=wr1 %h %h", i,
                 acc_wr_q[base+1+i], acc_addr_q[base+1+i], acc_data_q[base+1+i], ea, ed);
      end
    end
    checks++; if (ld_full !== 1'b0) begin failures++; $display("FAIL fifo_drained_full got=%0b exp=0", ld_full); end
  endtask

  task automatic test_round_robin;
    int n, gs_done, base;
    logic exp_wr [4];
    logic [ADDR_W-1:0] exp_addr [4];
    exp_wr[0] = 1'b1; exp_addr[0] = 21'h200;
    exp_wr[1] = 1'b0; exp_addr[1] = 21'h300;
    exp_wr[2] = 1'b1; exp_addr[2] = 21'h201;
    exp_wr[3] = 1'b0; exp_addr[3] = 21'h301;
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    base = acc_addr_q.size();
    ld_addr = 21'h200; ld_data = 8'h51; ld_wr = 1'b1;
    @(negedge clk_sys);
    ld_addr = 21'h201; ld_data = 8'h52;
    gs_addr = 21'h300; gs_rd = 1'b1;
    @(negedge clk_sys);
    ld_wr = 1'b0;
    gs_done = 0; n = 0;
    while (gs_done < 2 && n < 200) begin
      if (gs_rd && !gs_wait) begin
        gs_done++;
        if (gs_done == 2) gs_rd = 1'b0;
        else gs_addr = 21'h301;
      end
      @(negedge clk_sys); n++;
    end
    gs_rd = 1'b0;
    repeat (4) @(negedge clk_sys);
    checks++; if (acc_addr_q.size() != base + 4) begin failures++; $display("FAIL rr_count got=%0d exp=%0d", acc_addr_q.size() - base, 4); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (acc_wr_q[base+i] !== exp_wr[i] || acc_addr_q[base+i] !== exp_addr[i]) begin
        failures++;
        $display("FAIL rr_grant_%0d got=wr%0b %h exp=wr%0b %h", i, acc_wr_q[base+i], acc_addr_q[base+i], exp_wr[i], exp_addr[i]);
      end
    end
    checks++; if (gs_dout !== 8'h3D) begin failures++; $display("FAIL rr_gs_data got=%h exp=3d", gs_dout); end
  endtask

  task automatic test_reset_mid;
    int n, req0, s0;
    ready_en = 1'b0;
    gs_size = 2'd2;
    gs_addr = 21'h400; gs_rd = 1'b1;
    n = 0;
    while (!mem_rd && n < 20) begin @(negedge clk_sys); n++; end
    checks++; if (mem_rd !== 1'b1) begin failures++; $display("FAIL rstmid_active got=%0b exp=1", mem_rd); end
    ld_push(21'h500, 8'h99);
    reset = 1'b1; gs_rd = 1'b0;
    @(negedge clk_sys);
    checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL rstmid_mem_rd got=%0b exp=0", mem_rd); end
    reset = 1'b0;
    @(negedge clk_sys);
    req0 = req_cycles; s0 = acc_addr_q.size();
    kick = 1'b1;
    @(negedge clk_sys);
    kick = 1'b0;
    ready_en = 1'b1;
    repeat (6) @(negedge clk_sys);
    checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin failures++; $display("FAIL rstmid_idle got=rd%0b wr%0b exp=rd0 wr0", mem_rd, mem_wr); end
    checks++; if (gs_dout !== 8'hFF) begin failures++; $display("FAIL rstmid_gs_dout got=%h exp=ff", gs_dout); end
    checks++; if (ld_full !== 1'b0) begin failures++; $display("FAIL rstmid_ld_full got=%0b exp=0", ld_full); end
    checks++; if (req_cycles != req0) begin failures++; $display("FAIL rstmid_no_mem got=%0d exp=%0d", req_cycles, req0); end
    checks++; if (acc_addr_q.size() != s0) begin failures++; $display("FAIL rstmid_fifo_empty got=%0d exp=%0d", acc_addr_q.size(), s0); end
  endtask

  task automatic test_rdcache;
    int n, wr0, rd0;
    ready_en = 1'b1;
    gs_size = 2'd2;
    wr0 = wr_cnt;
    ld_push(21'h1234, 8'h11);
    n = 0;
    while (wr_cnt < wr0 + 1 && n < 50) begin @(negedge clk_sys); n++; end
    repeat (2) @(negedge clk_sys);
    rd0 = rd_cnt;
    gs_access(1'b1, 1'b0, 21'h1234, 8'h00, n);
    checks++; if (n != 3) begin failures++; $display("FAIL rc_first_latency got=%0d exp=3", n); end
    checks++; if (gs_dout !== 8'h11) begin failures++; $display("FAIL rc_first_data got=%h exp=11", gs_dout); end
    gs_access(1'b1, 1'b0, 21'h1234, 8'h00, n);
    checks++; if (gs_dout !== 8'h11) begin failures++; $display("FAIL rc_second_data got=%h exp=11", gs_dout); end
`ifdef GS_MEM_ARBITER_RDCACHE_EN
    checks++; if (n != 2) begin failures++; $display("FAIL rc_hit_latency got=%0d exp=2", n); end
    checks++; if (rd_cnt != rd0 + 1) begin failures++; $display("FAIL rc_hit_reads got=%0d exp=%0d", rd_cnt, rd0 + 1); end
`else
    checks++; if (n != 3) begin failures++; $display("FAIL rc_second_latency got=%0d exp=3", n); end
    checks++; if (rd_cnt != rd0 + 2) begin failures++; $display("FAIL rc_second_reads got=%0d exp=%0d", rd_cnt, rd0 + 2); end
`endif
    wr0 = wr_cnt;
    ld_push(21'h1234, 8'h22);
    n = 0;
    while (wr_cnt < wr0 + 1 && n < 50) begin @(negedge clk_sys); n++; end
    repeat (2) @(negedge clk_sys);
    rd0 = rd_cnt;
    gs_access(1'b1, 1'b0, 21'h1234, 8'h00, n);
    checks++; if (gs_dout !== 8'h22) begin failures++; $display("FAIL rc_inval_data got=%h exp=22", gs_dout); end
    checks++; if (rd_cnt != rd0 + 1) begin failures++; $display("FAIL rc_inval_reads got=%0d exp=%0d", rd_cnt, rd0 + 1); end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; gs_size = 2'd2; gs_addr = '0; gs_din = 8'h00;
    gs_rd = 1'b0; gs_wr = 1'b0; ld_wr = 1'b0; ld_addr = '0; ld_data = 8'h00;
    ready_en = 1'b1; kick = 1'b0;
    test_reset();
    test_gs_rw();
    test_oor();
    test_fifo_full();
    test_round_robin();
    test_reset_mid();
    test_rdcache();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
